// File: rtl/up_dwn_cntr_ctrl.sv
// up_dwn_cntr_ctrl: command sequencer for the up/down counter datapath.
// Accepts CLEAR/UP/DOWN/LOAD over valid/ready; steps on a prescaler tick.
//
// Ports:
//   clk, rst           single clock; async active-low reset
//   cmd_valid/ready    command handshake (ready only in IDLE)
//   cmd_op, cmd_arg    00 CLEAR, 01 UP, 10 DOWN, 11 LOAD; step count or value
//   abort              stops a running UP/DOWN, no done pulse
//   cnt                registered counter value
//   tick, busy         prescaler terminal pulse and RUN indication
//   done, wrap         completion and wrap-around one-cycle pulses
module up_dwn_cntr_ctrl #(
    parameter int WIDTH    = 3,
    parameter int TICK_DIV = 200000000,
    parameter int DIV_W    = 28
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    input  logic             abort,
    output logic [WIDTH-1:0] cnt,
    output logic             tick,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_DOWN  = 2'b10;
    localparam logic [1:0] OP_LOAD  = 2'b11;

    localparam logic [DIV_W-1:0] TICK_LAST = DIV_W'(TICK_DIV - 1);

    logic [1:0]       state;
    logic [DIV_W-1:0] presc;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] cnt_q;
    logic             dir_down;
    logic             done_q;
    logic             wrap_q;

    logic             accept;
    logic [WIDTH-1:0] cnt_step;
    logic             step_wraps;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state == S_RUN);
    assign tick      = busy && (presc == TICK_LAST);
    assign accept    = cmd_valid && cmd_ready;

    assign cnt  = cnt_q;
    assign done = done_q;
    assign wrap = wrap_q;

    // Next value and wrap detection for one step in the latched direction.
    assign cnt_step   = dir_down ? cnt_q - 1'b1 : cnt_q + 1'b1;
    assign step_wraps = dir_down ? (cnt_q == '0) : (cnt_q == '1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            presc    <= '0;
            rem      <= '0;
            cnt_q    <= '0;
            dir_down <= 1'b0;
            done_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            wrap_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        unique case (1'b1)
                            (cmd_op == OP_CLEAR): begin
                                cnt_q  <= '0;
                                state  <= S_DONE;
                                done_q <= 1'b1;
                            end
                            (cmd_op == OP_LOAD): begin
                                cnt_q  <= cmd_arg;
                                state  <= S_DONE;
                                done_q <= 1'b1;
                            end
                            default: begin
                                if (cmd_arg == '0) begin
                                    state  <= S_DONE;
                                    done_q <= 1'b1;
                                end else begin
                                    rem      <= cmd_arg;
                                    dir_down <= (cmd_op == OP_DOWN);
                                    presc    <= '0;
                                    state    <= S_RUN;
                                end
                            end
                        endcase
                    end
                end
                S_RUN: begin
                    // Abort takes priority over a coincident tick.
                    if (abort) begin
                        state <= S_IDLE;
                        presc <= '0;
                        rem   <= '0;
                    end else if (tick) begin
                        presc  <= '0;
                        cnt_q  <= cnt_step;
                        wrap_q <= step_wraps;
                        rem    <= rem - 1'b1;
                        if (rem == WIDTH'(1)) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
